// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with a 2-flop input synchronizer,
// optional parity and one stop bit. Mid-bit sampling uses an external tick.
module uart_rx #(
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLING = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLING - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLING / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [CW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_armed;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;

  logic                 w_mid;
  logic                 w_cnt_clr;
  logic                 w_bit_clr;
  logic                 w_shift_en;
  logic                 w_par_en;
  logic                 w_accept;
  logic                 w_ferr;
  logic                 w_par_err;

  assign w_mid     = tick && (r_tick_cnt == CNT_LAST);
  assign w_par_err = (PARITY_EN != 0) ? ((^r_shift) ^ r_par_bit ^ ODD) : 1'b0;

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != IDLE);

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_bit_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_accept    = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (tick && !r_rx_s && r_armed) w_state_nxt = START;
      end
      START: begin
        if (tick && (r_tick_cnt == CNT_HALF)) begin
          if (r_rx_s) begin
            w_state_nxt = IDLE;
          end else begin
            w_cnt_clr   = 1'b1;
            w_bit_clr   = 1'b1;
            w_state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (w_mid) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == BIT_LAST) w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (w_mid) begin
          w_par_en    = 1'b1;
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_mid) begin
          if (r_rx_s) w_accept = 1'b1;
          else        w_ferr   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Tick counter, bit counter and LSB-first shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
    end else begin
      if (w_cnt_clr)  r_tick_cnt <= '0;
      else if (tick)  r_tick_cnt <= (r_tick_cnt == CNT_LAST) ? '0 : r_tick_cnt + CW'(1);
      if (w_bit_clr)       r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= r_bit_cnt + BW'(1);
      if (w_shift_en) r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
      if (w_par_en)   r_par_bit <= r_rx_s;
    end
  end

  // Frame results; a low stop bit disarms start detection until the line
  // has been seen high again, so a held break reports only one error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_armed      <= 1'b1;
    end else begin
      r_rx_valid  <= w_accept;
      r_frame_err <= w_ferr;
      if (w_accept) begin
        r_rx_data    <= r_shift;
        r_parity_err <= w_par_err;
      end
      if (w_ferr)      r_armed <= 1'b0;
      else if (r_rx_s) r_armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 and 8E1 receivers with tick-aligned serial frames
// and checks every cycle against an event-queue model of the expected output.
module tb_uart_rx;

  localparam int OS       = 16;
  localparam int HALF     = OS / 2;
  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n0, rst_n1;
  logic       tick;
  logic       rx0, rx1;
  logic [7:0] rxd0, rxd1;
  logic       vld0, vld1, perr0, perr1, ferr0, ferr1, bsy0, bsy1;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLING(OS), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n0), .tick(tick), .rx(rx0), .rx_data(rxd0),
    .rx_valid(vld0), .parity_err(perr0), .frame_err(ferr0), .busy(bsy0));

  uart_rx #(.DATA_BITS(8), .OVERSAMPLING(OS), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .tick(tick), .rx(rx1), .rx_data(rxd1),
    .rx_valid(vld1), .parity_err(perr1), .frame_err(ferr1), .busy(bsy1));

  initial forever #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int tick_id;
  int last_tid;
  bit last_sampled;
  int cur_tid;
  bit cmp_on = 1'b0;

  typedef struct packed {
    int         stop_tick;
    logic       is_valid;
    logic [7:0] data;
    logic       perr;
  } ev_t;

  ev_t        q0[$];
  ev_t        q1[$];
  logic [7:0] m_data[2];
  logic       m_perr[2];
  int         busy_from[2];
  int         busy_to[2];
  int         valid_cnt[2];
  int         ferr_cnt[2];
  int         pulse_tid[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Tick generator: one-clk pulse every TICK_DIV clocks; records which tick
  // the DUTs sampled on the previous rising edge.
  initial begin
    tick = 1'b0; tick_id = 0; last_tid = -1; last_sampled = 1'b0;
    for (int div = 0; ; ) begin
      @(posedge clk);
      #1;
      last_sampled = tick;
      if (tick) last_tid = tick_id;
      div  = (div + 1) % TICK_DIV;
      tick = (div == 0);
      if (tick) tick_id++;
    end
  end

  task automatic cmp_dut(input int u, input logic [7:0] d, input logic v, input logic f,
                         input logic p, input logic b);
    ev_t e;
    bit  has, pulse, ev, ef, eb;
    e   = '0;
    has = (u == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (has) e = (u == 0) ? q0[0] : q1[0];
    pulse = has && last_sampled && (e.stop_tick == last_tid);
    ev = pulse && e.is_valid;
    ef = pulse && !e.is_valid;
    if (ev) begin
      m_data[u] = e.data;
      m_perr[u] = e.perr;
    end
    if (pulse) begin
      if (u == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
    eb = (last_tid >= busy_from[u]) && (last_tid < busy_to[u]);
    if (v) valid_cnt[u]++;
    if (f) ferr_cnt[u]++;
    if (v || f) pulse_tid[u] = last_tid;
    chk($sformatf("dut%0d rx_valid", u),   32'(v), 32'(ev));
    chk($sformatf("dut%0d frame_err", u),  32'(f), 32'(ef));
    chk($sformatf("dut%0d rx_data", u),    32'(d), 32'(m_data[u]));
    chk($sformatf("dut%0d parity_err", u), 32'(p), 32'(m_perr[u]));
    chk($sformatf("dut%0d busy", u),       32'(b), 32'(eb));
  endtask

  // Per-cycle comparison of both receivers against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        cmp_dut(0, rxd0, vld0, ferr0, perr0, bsy0);
        cmp_dut(1, rxd1, vld1, ferr1, perr1, bsy1);
      end
    end
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_tick();
    @(posedge clk);
    while (tick !== 1'b1) @(posedge clk);
    cur_tid = tick_id;
    #2;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic set_rx(input int u, input logic v);
    if (u == 0) rx0 = v;
    else        rx1 = v;
  endtask

  // Sends one frame starting right after the current tick (after gap ticks);
  // dut1 frames carry a parity bit. A low stop may be extended by extra_low.
  task automatic send_frame(input int u, input logic [7:0] data, input logic pbit,
                            input logic stop, input int gap, input int extra_low,
                            output int k);
    int  nb;
    ev_t e;
    nb = (u == 1) ? 9 : 8;
    wait_ticks(gap);
    k = cur_tid;
    e.stop_tick = k + 1 + HALF + OS * (1 + nb);
    e.is_valid  = stop;
    e.data      = data;
    e.perr      = (u == 1) ? (((($countones(data) + int'(pbit)) % 2) != 0) ? 1'b1 : 1'b0) : 1'b0;
    busy_from[u] = k + 1;
    busy_to[u]   = e.stop_tick;
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
    set_rx(u, 1'b0);
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      set_rx(u, data[i]);
      wait_ticks(OS);
    end
    if (u == 1) begin
      set_rx(u, pbit);
      wait_ticks(OS);
    end
    set_rx(u, stop);
    wait_ticks(OS);
    if (extra_low > 0) wait_ticks(extra_low);
    set_rx(u, 1'b1);
  endtask

  task automatic glitch(input int len);
    int k;
    wait_ticks(2);
    k = cur_tid;
    busy_from[0] = k + 1;
    busy_to[0]   = k + 1 + HALF;
    set_rx(0, 1'b0);
    wait_ticks(len);
    set_rx(0, 1'b1);
    wait_ticks(12);
  endtask

  initial begin
    int k, t1, vc, fc;
    bit prev_bad;
    for (int u = 0; u < 2; u++) begin
      m_data[u] = '0; m_perr[u] = 1'b0; busy_from[u] = 0; busy_to[u] = 0;
      valid_cnt[u] = 0; ferr_cnt[u] = 0; pulse_tid[u] = -1;
    end
    rst_n0 = 1'b0; rst_n1 = 1'b0; rx0 = 1'b1; rx1 = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("reset rx_data",    32'(rxd0),  32'h0);
    chk("reset rx_valid",   32'(vld0),  32'h0);
    chk("reset frame_err",  32'(ferr0), 32'h0);
    chk("reset parity_err", 32'(perr1), 32'h0);
    chk("reset busy",       32'(bsy0),  32'h0);
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    cmp_on = 1'b1;
    wait_tick();

    // 0xA5 8N1
    send_frame(0, 8'hA5, 1'b0, 1'b1, 2, 0, k);
    chk("A5 data",    32'(rxd0), 32'hA5);
    chk("A5 valids",  32'(valid_cnt[0]), 32'd1);
    chk("A5 latency", 32'(pulse_tid[0]), 32'(k + 153));
    chk("A5 busy",    32'(bsy0), 32'h0);

    // 4-tick low glitch on idle line
    glitch(4);
    chk("glitch busy",   32'(bsy0), 32'h0);
    chk("glitch valids", 32'(valid_cnt[0]), 32'd1);

    // 0x3C with low stop bit
    send_frame(0, 8'h3C, 1'b0, 1'b0, 3, 0, k);
    chk("badstop ferr",   32'(ferr_cnt[0]), 32'd1);
    chk("badstop data",   32'(rxd0), 32'hA5);
    chk("badstop valids", 32'(valid_cnt[0]), 32'd1);

    // break: line held low well past the stop bit
    send_frame(0, 8'h00, 1'b0, 1'b0, 2, 40, k);
    chk("break ferr",   32'(ferr_cnt[0]), 32'd2);
    chk("break valids", 32'(valid_cnt[0]), 32'd1);

    // back-to-back 0x55, 0xAA
    send_frame(0, 8'h55, 1'b0, 1'b1, 2, 0, k);
    chk("b2b first", 32'(rxd0), 32'h55);
    t1 = pulse_tid[0];
    send_frame(0, 8'hAA, 1'b0, 1'b1, 0, 0, k);
    chk("b2b second",  32'(rxd0), 32'hAA);
    chk("b2b spacing", 32'(pulse_tid[0] - t1), 32'd160);

    // reset during data bit 4
    vc = valid_cnt[0]; fc = ferr_cnt[0];
    wait_ticks(2);
    k = cur_tid;
    busy_from[0] = k + 1; busy_to[0] = k + 1000;
    set_rx(0, 1'b0);
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      set_rx(0, i[0]);
      wait_ticks(OS);
    end
    set_rx(0, 1'b1);
    wait_ticks(HALF);
    chk("pre-reset busy", 32'(bsy0), 32'h1);
    rst_n0 = 1'b0; rx0 = 1'b1;
    q0.delete();
    m_data[0] = '0; m_perr[0] = 1'b0; busy_from[0] = 0; busy_to[0] = 0;
    #1;
    chk("midreset rx_data",  32'(rxd0),  32'h0);
    chk("midreset rx_valid", 32'(vld0),  32'h0);
    chk("midreset ferr",     32'(ferr0), 32'h0);
    chk("midreset perr",     32'(perr0), 32'h0);
    chk("midreset busy",     32'(bsy0),  32'h0);
    repeat (3) @(posedge clk);
    #2;
    rst_n0 = 1'b1;
    wait_tick();
    chk("midreset no pulse", 32'(valid_cnt[0] + ferr_cnt[0]), 32'(vc + fc));
    send_frame(0, 8'h81, 1'b0, 1'b1, 2, 0, k);
    chk("after reset data", 32'(rxd0), 32'h81);

    // even parity receiver
    send_frame(1, 8'h07, 1'b1, 1'b1, 2, 0, k);
    chk("par ok data", 32'(rxd1),  32'h07);
    chk("par ok perr", 32'(perr1), 32'h0);
    send_frame(1, 8'h07, 1'b0, 1'b1, 2, 0, k);
    chk("par bad perr",   32'(perr1), 32'h1);
    chk("par bad valids", 32'(valid_cnt[1]), 32'd2);

    // randomized traffic, 8N1
    prev_bad = 1'b0;
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        glitch(int'($urandom_range(1, 7)));
        prev_bad = 1'b0;
      end else begin
        logic stop;
        stop = ($urandom_range(0, 7) != 0);
        send_frame(0, 8'($urandom), 1'b0, stop,
                   prev_bad ? int'($urandom_range(1, 10)) : int'($urandom_range(0, 10)),
                   stop ? 0 : int'($urandom_range(0, 20)), k);
        prev_bad = !stop;
      end
    end

    // randomized traffic, 8E1
    prev_bad = 1'b0;
    for (int n = 0; n < 15; n++) begin
      logic stop;
      stop = ($urandom_range(0, 7) != 0);
      send_frame(1, 8'($urandom), 1'($urandom), stop,
                 prev_bad ? int'($urandom_range(1, 10)) : int'($urandom_range(0, 10)), 0, k);
      prev_bad = !stop;
    end

    wait_ticks(4);
    chk("dut0 events drained", 32'(q0.size()), 32'd0);
    chk("dut1 events drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
